// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes used by the ALU control unit and the
// multiplier sequencer, plus the sequencer state encoding.
package alu_pkg;

  localparam int ALU_WIDTH  = 64;
  localparam int ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ADD   = 2'd2,
    DONE  = 2'd3
  } mul_state_t;

endpackage

// File: rtl/alu.sv
// Shared combinational datapath ALU. The multiplier sequencer borrows it
// while busy; the zero flag reflects the full-width result.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int CTRL_W = ALU_CTRL_W
) (
  input  logic [WIDTH-1:0]  in1,
  input  logic [WIDTH-1:0]  in2,
  input  logic [CTRL_W-1:0] ctrl,
  output logic [WIDTH-1:0]  result,
  output logic              zero
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    result = '0;
    case (ctrl)
      ALU_AND: result = in1 & in2;
      ALU_OR:  result = in1 | in2;
      ALU_ADD: result = in1 + in2;
      ALU_SUB: result = in1 - in2;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle unsigned shift-and-add multiplier (low WIDTH bits of product)
// that performs its additions and zero tests through the shared external ALU.
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  multiplicand,
  input  logic [WIDTH-1:0]  multiplier,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  product,
  output logic [WIDTH-1:0]  alu_in1,
  output logic [WIDTH-1:0]  alu_in2,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero
);

  mul_state_t       state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= multiplicand;
            mplier <= multiplier;
            acc    <= '0;
            busy   <= 1'b1;
            state  <= CHECK;
          end
        end
        CHECK: begin
          // The ALU ORs mplier with zero, so its zero flag ends the loop.
          if (alu_zero) begin
            product <= acc;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else if (mplier[0]) begin
            state <= ADD;
          end else begin
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
        end
        ADD: begin
          acc    <= alu_result;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          state  <= CHECK;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // ALU request is decoded from state so the result is usable in the same cycle.
  always_comb begin
    alu_in1  = '0;
    alu_in2  = '0;
    alu_ctrl = ALU_AND;
    case (state)
      CHECK: begin
        alu_in1  = mplier;
        alu_ctrl = ALU_OR;
      end
      ADD: begin
        alu_in1  = acc;
        alu_in2  = mcand;
        alu_ctrl = ALU_ADD;
      end
      default: ;
    endcase
  end

endmodule
